// File: rtl/stepper_pkg.sv
// Shared constants and state encoding for the stepper step generator.
package stepper_pkg;

  localparam int DEF_PERIOD_W = 32;
  localparam int DEF_COUNT_W  = 16;
  localparam int MIN_PERIOD   = 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCEL  = 2'd1;
  localparam state_t ST_CRUISE = 2'd2;
  localparam state_t ST_DECEL  = 2'd3;

endpackage

// File: rtl/stepper_step_generator_if.sv
// Move-command / step-output bundle between the host register block and the step generator.
interface stepper_step_generator_if #(
  parameter int PERIOD_W = stepper_pkg::DEF_PERIOD_W,
  parameter int COUNT_W  = stepper_pkg::DEF_COUNT_W
);
  import stepper_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  logic [COUNT_W-1:0]  cmd_steps;
  logic                cmd_dir;
  logic [PERIOD_W-1:0] cmd_period;
  logic                abort;
  logic                step_pulse;
  logic                step_dir;
  logic                busy;
  logic                done;
  logic [COUNT_W-1:0]  steps_remaining;

  modport master (
    output cmd_valid, cmd_steps, cmd_dir, cmd_period, abort,
    input  cmd_ready, step_pulse, step_dir, busy, done, steps_remaining
  );

  modport slave (
    input  cmd_valid, cmd_steps, cmd_dir, cmd_period, abort,
    output cmd_ready, step_pulse, step_dir, busy, done, steps_remaining
  );

endinterface

// File: rtl/stepper_period_timer.sv
// Loadable interval down-counter; expire is high in the single cycle where the count is 1, so an owner
// that reloads on that edge sees intervals of exactly `period` cycles. Zero-latency load, no backpressure.
module stepper_period_timer
  import stepper_pkg::*;
#(
  parameter int PERIOD_W = DEF_PERIOD_W
) (
  input  logic                clock_clk,
  input  logic                reset_low,
  input  logic                load,
  input  logic [PERIOD_W-1:0] period,
  input  logic                clear,
  output logic                expire
);

  logic [PERIOD_W-1:0] r_cnt;

  always_ff @(posedge clock_clk or negedge reset_low) begin
    if (!reset_low) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= period;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - PERIOD_W'(1);
    end
  end

  assign expire = (r_cnt == PERIOD_W'(1));

endmodule

// File: rtl/stepper_step_generator.sv
// Trapezoidal step generator: first step cur_period cycles after accept, registered one-cycle step/done strobes.
// Commands are only taken in IDLE (cmd_ready); abort ends a move on the next edge.
module stepper_step_generator
  import stepper_pkg::*;
#(
  parameter int PERIOD_W     = DEF_PERIOD_W,
  parameter int COUNT_W      = DEF_COUNT_W,
  parameter int START_PERIOD = 1_000_000,
  parameter int RAMP_STEP    = 10_000
) (
  input  logic                    clock_clk,
  input  logic                    reset_low,
  stepper_step_generator_if.slave bus
);

  localparam logic [PERIOD_W-1:0] START_P = PERIOD_W'(START_PERIOD);
  localparam logic [PERIOD_W-1:0] RAMP_P  = PERIOD_W'(RAMP_STEP);
  localparam logic [PERIOD_W-1:0] MIN_P   = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W:0]   START_X = {1'b0, START_P};
  localparam logic [PERIOD_W:0]   RAMP_X  = {1'b0, RAMP_P};

  state_t              r_state;
  state_t              w_state_n;
  logic                r_dir;
  logic                r_pulse;
  logic                r_done;
  logic                r_last;
  logic                r_zero_pend;
  logic [COUNT_W-1:0]  r_rem;
  logic [COUNT_W-1:0]  r_ramp;
  logic [COUNT_W-1:0]  w_ramp_n;
  logic [COUNT_W-1:0]  w_rem_n;
  logic [COUNT_W-1:0]  w_ramp_dec;
  logic [PERIOD_W-1:0] r_cur;
  logic [PERIOD_W-1:0] r_target;
  logic [PERIOD_W-1:0] w_cur_n;
  logic [PERIOD_W-1:0] w_target_in;
  logic [PERIOD_W-1:0] w_acc_p;
  logic [PERIOD_W-1:0] w_dec_p;
  logic [PERIOD_W:0]   w_sum;
  logic                w_moving;
  logic                w_accept;
  logic                w_zero_cmd;
  logic                w_abort;
  logic                w_step;
  logic                w_expire;
  logic                w_load;
  logic                w_clear;
  logic                w_enter_decel;

  assign w_moving    = (r_state != ST_IDLE);
  assign w_accept    = bus.cmd_valid && !w_moving;
  assign w_zero_cmd  = (bus.cmd_steps == '0);
  assign w_target_in = (bus.cmd_period < MIN_P) ? MIN_P : bus.cmd_period;

  // r_last marks the cycle after the final step; the move is already complete there.
  assign w_abort = w_moving && !r_last && bus.abort;
  assign w_step  = w_moving && !r_last && !bus.abort && w_expire;
  assign w_rem_n = r_rem - COUNT_W'(1);

  // Saturating ramp arithmetic evaluated one bit wider than the period.
  assign w_sum      = {1'b0, r_cur} + RAMP_X;
  assign w_dec_p    = (w_sum > START_X) ? START_P : w_sum[PERIOD_W-1:0];
  assign w_acc_p    = ({1'b0, r_cur} >= RAMP_X + {1'b0, r_target}) ? (r_cur - RAMP_P) : r_target;
  assign w_ramp_dec = (r_ramp == '0) ? '0 : (r_ramp - COUNT_W'(1));

  assign w_enter_decel = (r_state == ST_DECEL) || (w_rem_n <= r_ramp);

  always_comb begin
    w_state_n = r_state;
    w_cur_n   = r_cur;
    w_ramp_n  = r_ramp;
    w_load    = 1'b0;
    w_clear   = 1'b0;
    if (w_accept && !w_zero_cmd) begin
      w_ramp_n = '0;
      w_load   = 1'b1;
      if ({1'b0, w_target_in} >= START_X) begin
        w_cur_n   = w_target_in;
        w_state_n = ST_CRUISE;
      end else begin
        w_cur_n   = START_P;
        w_state_n = ST_ACCEL;
      end
    end else if (r_last || w_abort) begin
      w_state_n = ST_IDLE;
      w_clear   = 1'b1;
    end else if (w_step) begin
      if (w_rem_n == '0) begin
        // Stay busy one more cycle so busy falls on the edge after done.
        w_clear = 1'b1;
      end else begin
        w_load = 1'b1;
        if (w_enter_decel) begin
          w_state_n = ST_DECEL;
          w_cur_n   = w_dec_p;
          w_ramp_n  = w_ramp_dec;
        end else if (r_state == ST_ACCEL) begin
          w_cur_n  = w_acc_p;
          w_ramp_n = r_ramp + COUNT_W'(1);
          if (w_acc_p == r_target) begin
            w_state_n = ST_CRUISE;
          end
        end
      end
    end
  end

  always_ff @(posedge clock_clk or negedge reset_low) begin
    if (!reset_low) begin
      r_state     <= ST_IDLE;
      r_dir       <= 1'b0;
      r_pulse     <= 1'b0;
      r_done      <= 1'b0;
      r_last      <= 1'b0;
      r_zero_pend <= 1'b0;
      r_rem       <= '0;
      r_ramp      <= '0;
      r_cur       <= '0;
      r_target    <= '0;
    end else begin
      r_state     <= w_state_n;
      r_cur       <= w_cur_n;
      r_ramp      <= w_ramp_n;
      r_pulse     <= w_step;
      r_last      <= w_step && (w_rem_n == '0);
      r_done      <= (w_step && (w_rem_n == '0)) || w_abort || r_zero_pend;
      r_zero_pend <= w_accept && w_zero_cmd;
      if (w_accept) begin
        r_dir    <= bus.cmd_dir;
        r_rem    <= bus.cmd_steps;
        r_target <= w_target_in;
      end else if (w_step) begin
        r_rem <= w_rem_n;
      end
    end
  end

  stepper_period_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clock_clk (clock_clk),
    .reset_low (reset_low),
    .load      (w_load),
    .period    (w_cur_n),
    .clear     (w_clear),
    .expire    (w_expire)
  );

  assign bus.cmd_ready       = !w_moving;
  assign bus.busy            = w_moving;
  assign bus.step_pulse      = r_pulse;
  assign bus.done            = r_done;
  assign bus.step_dir        = r_dir;
  assign bus.steps_remaining = r_rem;

endmodule

// File: tb/tb_stepper_step_generator.sv
// Randomized bench for stepper_step_generator; expected step timing comes from a plain-arithmetic move planner.
module tb_stepper_step_generator;
  import stepper_pkg::*;

  localparam int PW = 32;
  localparam int CW = 16;
  localparam int SP = 20;
  localparam int RS = 5;

  logic clock_clk = 1'b0;
  logic reset_low = 1'b0;
  always #5 clock_clk = ~clock_clk;

  stepper_step_generator_if #(.PERIOD_W(PW), .COUNT_W(CW)) bus ();

  stepper_step_generator #(
    .PERIOD_W     (PW),
    .COUNT_W      (CW),
    .START_PERIOD (SP),
    .RAMP_STEP    (RS)
  ) dut (
    .clock_clk (clock_clk),
    .reset_low (reset_low),
    .bus       (bus)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  int   move_id  = 0;
  logic exp_dir  = 1'b0;
  int   exp_iv[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (rem,ready,dir,pulse,done,busy)", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] obs();
    return {43'd0, bus.steps_remaining, bus.cmd_ready, bus.step_dir, bus.step_pulse, bus.done, bus.busy};
  endfunction

  function automatic logic [63:0] pack_exp(input int rem, input logic ready, input logic dir,
                                           input logic pulse, input logic done, input logic busy);
    return {43'd0, CW'(rem), ready, dir, pulse, done, busy};
  endfunction

  // Interval list of a move, straight from the ramp rules.
  task automatic build_plan(input int steps, input int per);
    longint target, cur, rc, rem;
    bit     ramping, decel;
    exp_iv.delete();
    target  = (per < 2) ? 2 : per;
    ramping = (target < SP);
    cur     = ramping ? SP : target;
    decel   = 0;
    rc      = 0;
    rem     = steps;
    while (rem > 0) begin
      exp_iv.push_back(int'(cur));
      rem--;
      if (rem > 0) begin
        if (!decel && rem <= rc) decel = 1;
        if (decel) begin
          cur = (cur + RS > SP) ? SP : cur + RS;
          rc  = (rc > 0) ? rc - 1 : 0;
        end else if (ramping) begin
          cur = (cur - RS < target) ? target : cur - RS;
          rc++;
          if (cur == target) ramping = 0;
        end
      end
    end
  endtask

  // abort_edge: edge (counted from accept) whose sampled abort ends the move, 0 = none.
  // stray: cycle in which a foreign cmd_valid is driven during the move, -1 = none.
  task automatic run_move(input int steps, input int per, input logic dir,
                          input int abort_edge, input int stray);
    int cum[$];
    int total;
    int end_edge;
    total = 0;
    build_plan(steps, per);
    foreach (exp_iv[i]) begin
      total += exp_iv[i];
      cum.push_back(total);
    end
    end_edge = (steps == 0) ? 1 : ((abort_edge > 0) ? abort_edge : total);
    move_id++;
    chk($sformatf("m%0d ready", move_id), 64'(bus.cmd_ready), 64'(1));
    bus.cmd_valid  = 1'b1;
    bus.cmd_steps  = CW'(steps);
    bus.cmd_dir    = dir;
    bus.cmd_period = PW'(per);
    @(posedge clock_clk);
    exp_dir = dir;
    for (int c = 0; c <= end_edge + 1; c++) begin
      int   issued;
      logic pulse_e, done_e, busy_e;
      @(negedge clock_clk);
      issued  = 0;
      pulse_e = 1'b0;
      foreach (cum[i]) begin
        if (abort_edge == 0 || cum[i] < abort_edge) begin
          if (cum[i] <= c) issued++;
          if (cum[i] == c) pulse_e = 1'b1;
        end
      end
      done_e = (c == end_edge);
      busy_e = (steps != 0) && ((abort_edge > 0) ? (c < abort_edge) : (c <= total));
      chk($sformatf("m%0d c%0d", move_id, c), obs(),
          pack_exp(steps - issued, !busy_e, exp_dir, pulse_e, done_e, busy_e));
      bus.cmd_valid = (stray >= 0) && (c == stray);
      bus.abort     = (abort_edge > 0) && (c == abort_edge - 1);
      if (bus.cmd_valid) begin
        bus.cmd_steps  = CW'(7);
        bus.cmd_period = PW'(3);
        bus.cmd_dir    = ~dir;
      end
    end
  endtask

  task automatic reset_mid_move();
    move_id++;
    chk($sformatf("m%0d ready", move_id), 64'(bus.cmd_ready), 64'(1));
    bus.cmd_valid  = 1'b1;
    bus.cmd_steps  = CW'(5);
    bus.cmd_dir    = 1'b1;
    bus.cmd_period = PW'(20);
    @(posedge clock_clk);
    for (int c = 0; c <= 20; c++) begin
      @(negedge clock_clk);
      bus.cmd_valid = 1'b0;
    end
    chk("rst pre", obs(), pack_exp(4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
    #2 reset_low = 1'b0;
    #1 chk("rst async", obs(), pack_exp(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int k = 0; k < 3; k++) begin
      @(negedge clock_clk);
      chk($sformatf("rst hold%0d", k), obs(), pack_exp(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    reset_low = 1'b1;
    exp_dir   = 1'b0;
    @(negedge clock_clk);
    chk("rst release", obs(), pack_exp(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_steps  = '0;
    bus.cmd_dir    = 1'b0;
    bus.cmd_period = '0;
    bus.abort      = 1'b0;
    repeat (3) @(negedge clock_clk);
    chk("reset", obs(), pack_exp(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    reset_low = 1'b1;
    @(negedge clock_clk);

    run_move(3, 20, 1'b0, 0, -1);
    run_move(10, 10, 1'b1, 0, -1);
    run_move(0, 20, 1'b0, 0, -1);
    run_move(8, 20, 1'b1, 60, -1);
    reset_mid_move();
    run_move(20, 1, 1'b1, 0, 7);
    run_move(1, 50, 1'b0, 0, -1);

    for (int m = 0; m < 14; m++) begin
      int   st, pr, tot, ab, sy;
      logic dr;
      st  = $urandom_range(0, 25);
      pr  = $urandom_range(0, 40);
      dr  = 1'($urandom_range(0, 1));
      build_plan(st, pr);
      tot = 0;
      foreach (exp_iv[i]) tot += exp_iv[i];
      ab = 0;
      sy = -1;
      if (st != 0 && $urandom_range(0, 3) == 0) ab = $urandom_range(1, tot);
      if (st != 0 && $urandom_range(0, 1) == 0) sy = $urandom_range(0, ((ab != 0) ? ab : tot) - 1);
      run_move(st, pr, dr, ab, sy);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
